// File: rtl/qdec_ctx_ctrl.sv
// CABAC context memory controller: slice-start context initialisation from an
// initValue ROM, otherwise a pass-through port for the bin decoder.
module qdec_ctx_ctrl #(
    parameter int unsigned NUM_CTX = 186,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic [6:0]        slice_qp,
    output logic              init_busy,
    output logic              init_done,
    output logic [ADDR_W-1:0] initv_addr,
    input  logic [7:0]        initv_data,
    input  logic              dec_req,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [7:0]        dec_wdata,
    output logic              dec_gnt,
    output logic              dec_rvalid,
    output logic [7:0]        dec_rdata,
    output logic [ADDR_W-1:0] ctx_addr,
    output logic [7:0]        ctx_wdata,
    output logic              ctx_we,
    output logic              ctx_re,
    input  logic [7:0]        ctx_rdata
);

    typedef enum logic [1:0] {StIdle, StFill, StLast, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CTX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [5:0]        qpc_q, qpc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] ctx_addr_q, ctx_addr_d;

    logic              start_acc;
    logic              init_own;
    logic              init_we;
    logic [ADDR_W-1:0] init_waddr;
    logic [7:0]        init_wdata;
    logic [5:0]        qp_clip;

    logic signed [15:0] m, n, prod, pre_raw;
    logic        [6:0]  pre;
    logic        [6:0]  pstate;
    logic               val_mps;

    assign start_acc = (state_q == StIdle) && init_start;

    always_comb begin
        qp_clip = 6'd0;
        if ($signed(slice_qp) < 0) begin
            qp_clip = 6'd0;
        end else if ($signed(slice_qp) > 7'sd51) begin
            qp_clip = 6'd51;
        end else begin
            qp_clip = slice_qp[5:0];
        end
    end

    // initValue -> {valMps, pStateIdx}; 16-bit signed keeps every intermediate exact
    always_comb begin
        m       = $signed({12'b0, initv_data[7:4]}) * 16'sd5 - 16'sd45;
        n       = $signed({9'b0, initv_data[3:0], 3'b0}) - 16'sd16;
        prod    = m * $signed({10'b0, qpc_q});
        pre_raw = (prod >>> 4) + n;
        if (pre_raw < 16'sd1) begin
            pre = 7'd1;
        end else if (pre_raw > 16'sd126) begin
            pre = 7'd126;
        end else begin
            pre = pre_raw[6:0];
        end
        val_mps    = (pre > 7'd63);
        pstate     = val_mps ? (pre - 7'd64) : (7'd63 - pre);
        init_wdata = {1'b0, val_mps, pstate[5:0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qpc_d   = qpc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (init_start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    qpc_d   = qp_clip;
                    busy_d  = 1'b1;
                end
            end
            StFill: begin
                if (cnt_q == LastAddr) begin
                    state_d = StLast;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StLast: begin
                state_d = StDone;
                done_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Writes trail ROM addresses by one cycle because of the ROM read latency
    always_comb begin
        init_own   = busy_q || start_acc;
        init_we    = ((state_q == StFill) && (cnt_q != '0)) || (state_q == StLast);
        init_waddr = (state_q == StLast) ? cnt_q : (cnt_q - ADDR_W'(1));
        dec_gnt    = dec_req && !init_own;
        ctx_we     = init_we || (dec_gnt && dec_we);
        ctx_re     = dec_gnt && !dec_we;
        ctx_wdata  = init_we ? init_wdata : dec_wdata;
        if (init_we) begin
            ctx_addr = init_waddr;
        end else if (dec_gnt) begin
            ctx_addr = dec_addr;
        end else begin
            ctx_addr = ctx_addr_q;
        end
        ctx_addr_d = ctx_addr;
        rvalid_d   = ctx_re;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qpc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            ctx_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qpc_q      <= qpc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rvalid_q   <= rvalid_d;
            ctx_addr_q <= ctx_addr_d;
        end
    end

    assign init_busy  = busy_q;
    assign init_done  = done_q;
    assign initv_addr = cnt_q;
    assign dec_rvalid = rvalid_q;
    assign dec_rdata  = ctx_rdata;

endmodule

// File: tb/tb_qdec_ctx_ctrl.sv
// Directed bench for qdec_ctx_ctrl with a behavioural ROM and context memory.
module tb_qdec_ctx_ctrl;

    localparam int NUM_CTX = 186;
    localparam int ADDR_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_start;
    logic [6:0]        slice_qp;
    logic              init_busy, init_done;
    logic [ADDR_W-1:0] initv_addr;
    logic [7:0]        initv_data;
    logic              dec_req, dec_we;
    logic [ADDR_W-1:0] dec_addr;
    logic [7:0]        dec_wdata;
    logic              dec_gnt, dec_rvalid;
    logic [7:0]        dec_rdata;
    logic [ADDR_W-1:0] ctx_addr;
    logic [7:0]        ctx_wdata;
    logic              ctx_we, ctx_re;
    logic [7:0]        ctx_rdata;

    logic [7:0] rom [1024];
    logic [7:0] mem [1024];
    logic       mem_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qdec_ctx_ctrl #(.NUM_CTX(NUM_CTX), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .slice_qp   (slice_qp),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .initv_addr (initv_addr),
        .initv_data (initv_data),
        .dec_req    (dec_req),
        .dec_we     (dec_we),
        .dec_addr   (dec_addr),
        .dec_wdata  (dec_wdata),
        .dec_gnt    (dec_gnt),
        .dec_rvalid (dec_rvalid),
        .dec_rdata  (dec_rdata),
        .ctx_addr   (ctx_addr),
        .ctx_wdata  (ctx_wdata),
        .ctx_we     (ctx_we),
        .ctx_re     (ctx_re),
        .ctx_rdata  (ctx_rdata)
    );

    always @(posedge clk) initv_data <= rom[initv_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h11;
        end else if (ctx_we) begin
            mem[ctx_addr] <= ctx_wdata;
        end
        if (ctx_re) ctx_rdata <= mem[ctx_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rom(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) rom[i] = v;
    endtask

    // Starts an init in the current cycle (cycle 0) and steps until init_done.
    task automatic run_init(input logic [6:0] qp, input int inject_at,
                            output int done_cyc, output int writes, output int overlap,
                            output int gnt_leak, output logic rvalid0);
        int n;
        init_start = 1'b1;
        slice_qp   = qp;
        #1;
        rvalid0  = dec_rvalid;
        writes   = ctx_we ? 1 : 0;
        overlap  = (ctx_we && ctx_re) ? 1 : 0;
        gnt_leak = dec_gnt ? 1 : 0;
        done_cyc = -1;
        n = 0;
        while (n < 400 && done_cyc < 0) begin
            tick();
            n++;
            init_start = (n == inject_at);
            slice_qp   = (n == inject_at) ? 7'd51 : qp;
            #1;
            if (ctx_we) writes++;
            if (ctx_we && ctx_re) overlap++;
            if (dec_gnt) gnt_leak++;
            if (init_done) done_cyc = n;
        end
        init_start = 1'b0;
    endtask

    initial begin
        int   dc, wr, ov, gl, bad, found, seen_done;
        logic rv0;

        rst = 1'b1; init_start = 1'b0; slice_qp = '0;
        dec_req = 1'b0; dec_we = 1'b0; dec_addr = '0; dec_wdata = '0; mem_clr = 1'b0;
        set_rom(8'h9A);
        @(negedge clk);
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", init_busy, 0);
        chk("rst_done", init_done, 0);
        chk("rst_rvalid", dec_rvalid, 0);
        chk("rst_we", ctx_we, 0);
        chk("rst_re", ctx_re, 0);
        chk("rst_initv_addr", initv_addr, 0);
        tick();

        // T1/T4: decoder read held through init, qp=26, ROM 0x9A everywhere
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 10'd5;
        run_init(7'd26, -1, dc, wr, ov, gl, rv0);
        chk("t1_done_cycle", dc, NUM_CTX + 2);
        chk("t1_writes", wr, NUM_CTX);
        chk("t1_we_re_overlap", ov, 0);
        chk("t4_gnt_during_init", gl, 0);
        tick();
        chk("t4_gnt_after", dec_gnt, 1);
        chk("t4_re", ctx_re, 1);
        chk("t4_addr", ctx_addr, 5);
        chk("t4_busy_idle", init_busy, 0);
        tick();
        dec_req = 1'b0;
        #1;
        chk("t4_rvalid", dec_rvalid, 1);
        chk("t4_rdata", dec_rdata, 8'h40);
        chk("t1_mem0", mem[0], 8'h40);
        chk("t1_mem185", mem[185], 8'h40);
        chk("t1_mem186", mem[186], 8'h11);

        // T5: decoder write then read-back
        tick();
        dec_req = 1'b1; dec_we = 1'b1; dec_addr = 10'd3; dec_wdata = 8'h55;
        #1;
        chk("t5_wr_gnt", dec_gnt, 1);
        chk("t5_wr_we", ctx_we, 1);
        chk("t5_wr_re", ctx_re, 0);
        chk("t5_wr_data", ctx_wdata, 8'h55);
        chk("t5_wr_addr", ctx_addr, 3);
        tick();
        dec_we = 1'b0;
        #1;
        chk("t5_rd_re", ctx_re, 1);
        tick();
        dec_req = 1'b0; dec_addr = 10'd9;
        #1;
        chk("t5_rvalid", dec_rvalid, 1);
        chk("t5_rdata", dec_rdata, 8'h55);
        chk("t5_idle_we", ctx_we, 0);
        chk("t5_idle_re", ctx_re, 0);
        chk("t5_idle_addr_hold", ctx_addr, 3);

        // Granted read followed by init_start; T5 simultaneous start + request
        tick();
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 10'd3;
        #1;
        chk("rd_then_init_gnt", dec_gnt, 1);
        tick();
        set_rom(8'h8B);
        run_init(7'd26, -1, dc, wr, ov, gl, rv0);
        chk("rd_then_init_rvalid", rv0, 1);
        chk("t5_sim_start_gnt", gl, 0);
        chk("t2_8b_done", dc, NUM_CTX + 2);
        dec_req = 1'b0;
        tick();
        chk("t2_8b_mem10", mem[10], 8'h00);

        // T2: clip corners at qp=51
        set_rom(8'h9A);
        rom[0] = 8'h00;
        rom[1] = 8'hFF;
        run_init(7'd51, -1, dc, wr, ov, gl, rv0);
        tick();
        chk("t2_clip_lo", mem[0], 8'h3E);
        chk("t2_clip_hi", mem[1], 8'h7E);
        chk("t2_m0", mem[2], 8'h40);

        // T3: negative qp clips to 0; a start pulse while busy must be ignored
        set_rom(8'hFF);
        run_init(7'h7A, 20, dc, wr, ov, gl, rv0);
        chk("t3_done_cycle", dc, NUM_CTX + 2);
        chk("t3_writes", wr, NUM_CTX);
        tick();
        chk("t3_mem0", mem[0], 8'h68);
        chk("t3_mem185", mem[185], 8'h68);

        // T6: reset in the middle of FILL
        set_rom(8'h9A);
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        init_start = 1'b1; slice_qp = 7'd26;
        tick();
        init_start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (initv_addr == 10'd50) found = 1;
            else tick();
        end
        chk("t6_reached_cnt50", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_busy_cleared", init_busy, 0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (init_done) seen_done++;
            tick();
        end
        chk("t6_no_done", seen_done, 0);
        chk("t6_mem48", mem[48], 8'h40);
        chk("t6_mem100", mem[100], 8'h11);
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        run_init(7'd26, -1, dc, wr, ov, gl, rv0);
        chk("t6_restart_done", dc, NUM_CTX + 2);
        chk("t6_restart_writes", wr, NUM_CTX);
        tick();
        bad = 0;
        for (int i = 0; i < NUM_CTX; i++) if (mem[i] !== 8'h40) bad++;
        chk("t6_all_written", bad, 0);
        chk("t6_beyond", mem[NUM_CTX], 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
